// File: rtl/c17.sv
// ISCAS-85 c17 NAND cone with optional input and output register stages.
// Ports: clk, rst (async, active-high), N1/N2/N3/N6/N7 in, N22/N23 out.
module c17 #(
  parameter int IN_REG  = 1,
  parameter int OUT_REG = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N6,
  input  logic N7,
  output logic N22,
  output logic N23
);

  // Input vector packed as {N7,N6,N3,N2,N1}.
  logic [4:0] vin;
  logic [4:0] vq;

  assign vin = {N7, N6, N3, N2, N1};

  generate
    if (IN_REG != 0) begin : g_in_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vq <= '0;
        end else begin
          vq <= vin;
        end
      end
    end else begin : g_in_pass
      assign vq = vin;
    end
  endgenerate

  logic n10;
  logic n11;
  logic n16;
  logic n19;
  logic n22c;
  logic n23c;

  assign n10  = ~(vq[0] & vq[2]);
  assign n11  = ~(vq[2] & vq[3]);
  assign n16  = ~(vq[1] & n11);
  assign n19  = ~(n11 & vq[4]);
  assign n22c = ~(n10 & n16);
  assign n23c = ~(n16 & n19);

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          N22 <= 1'b0;
          N23 <= 1'b0;
        end else begin
          N22 <= n22c;
          N23 <= n23c;
        end
      end
    end else begin : g_out_pass
      assign N22 = n22c;
      assign N23 = n23c;
    end
  endgenerate

endmodule

// File: tb/tb_c17.sv
// Self-checking bench for c17: all four register configurations
// are driven in parallel and compared against a history-based model.
module tb_c17;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] vin = '0;

  logic [1:0] o11;
  logic [1:0] o10;
  logic [1:0] o01;
  logic [1:0] o00;

  int tests = 0;
  int fails = 0;

  // hist[j] = vector driven j clock edges ago (0 = live input).
  logic [4:0] hist [0:2];

  always #5 clk = ~clk;

  c17 #(.IN_REG(1), .OUT_REG(1)) u11 (
    .clk(clk), .rst(rst),
    .N1(vin[0]), .N2(vin[1]), .N3(vin[2]),
    .N6(vin[3]), .N7(vin[4]),
    .N22(o11[1]), .N23(o11[0])
  );

  c17 #(.IN_REG(1), .OUT_REG(0)) u10 (
    .clk(clk), .rst(rst),
    .N1(vin[0]), .N2(vin[1]), .N3(vin[2]),
    .N6(vin[3]), .N7(vin[4]),
    .N22(o10[1]), .N23(o10[0])
  );

  c17 #(.IN_REG(0), .OUT_REG(1)) u01 (
    .clk(clk), .rst(rst),
    .N1(vin[0]), .N2(vin[1]), .N3(vin[2]),
    .N6(vin[3]), .N7(vin[4]),
    .N22(o01[1]), .N23(o01[0])
  );

  c17 #(.IN_REG(0), .OUT_REG(0)) u00 (
    .clk(clk), .rst(rst),
    .N1(vin[0]), .N2(vin[1]), .N3(vin[2]),
    .N6(vin[3]), .N7(vin[4]),
    .N22(o00[1]), .N23(o00[0])
  );

  // Reference: {N22,N23} from the boolean equations, v = {N7,N6,N3,N2,N1}.
  function automatic logic [1:0] ref_f(logic [4:0] v);
    logic a1, a2, a3, a6, a7;
    a1 = v[0]; a2 = v[1]; a3 = v[2];
    a6 = v[3]; a7 = v[4];
    return {(a1 & a3) | (a2 & ~(a3 & a6)),
            ~(a3 & a6) & (a2 | a7)};
  endfunction

  task automatic check(string tag, logic [1:0] obs,
                       logic [1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, "/11"}, o11, ref_f(hist[2]));
    check({tag, "/10"}, o10, ref_f(hist[1]));
    check({tag, "/01"}, o01, ref_f(hist[1]));
    check({tag, "/00"}, o00, ref_f(hist[0]));
  endtask

  // One cycle: drive a vector mid-cycle, then check all outputs.
  task automatic apply(logic [4:0] v, string tag);
    @(negedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = v;
    vin = v;
    #1;
    check_all(tag);
  endtask

  // Reset pulse entirely between two rising edges.
  task automatic mid_reset(string tag);
    #1 rst = 1'b1;
    #1;
    hist[1] = '0;
    hist[2] = '0;
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  // Directed table, bits ordered N1,N2,N3,N6,N7 -> {N22,N23}.
  logic [4:0] tv [0:5];
  logic [1:0] te [0:5];

  initial begin
    logic [4:0] t;
    logic [4:0] v;
    tv[0] = 5'b00000; te[0] = 2'b00;
    tv[1] = 5'b10100; te[1] = 2'b10;
    tv[2] = 5'b01000; te[2] = 2'b11;
    tv[3] = 5'b00001; te[3] = 2'b01;
    tv[4] = 5'b01110; te[4] = 2'b00;
    tv[5] = 5'b11111; te[5] = 2'b10;

    // Reset with random inputs, before any clock edge.
    hist[1] = '0;
    hist[2] = '0;
    vin = 5'($urandom);
    hist[0] = vin;
    #1;
    check_all("rst_init");
    check("rst_init_n", o11, 2'b00);
    vin = '0;
    hist[0] = '0;
    @(negedge clk);
    #2 rst = 1'b0;

    // Exhaustive sweep with a mid-stream reset.
    for (int i = 0; i < 32; i++) begin
      apply(5'(i), "sweep");
      if (i == 16) mid_reset("sweep_rst");
    end
    apply(5'd3, "post_rst");
    apply(5'd5, "post_rst");

    // Directed vectors, also compared to the table directly.
    for (int i = 0; i < 6; i++) begin
      t = tv[i];
      v = {t[0], t[1], t[2], t[3], t[4]};
      apply(v, "dir");
      check("dir_tbl", o00, te[i]);
    end
    for (int i = 0; i < 6; i++) begin
      t = tv[i];
      v = {t[0], t[1], t[2], t[3], t[4]};
      apply(v, "dir2");
      apply(v, "dir2");
      apply(v, "dir2");
      check("dir_tbl11", o11, te[i]);
    end

    // Latency: 00000 -> 01000 (N2 only) rises exactly two edges later.
    apply(5'b00000, "lat");
    apply(5'b00000, "lat");
    apply(5'b00000, "lat");
    apply(5'b00010, "lat");
    check("lat_k0", o11, 2'b00);
    check("lat_k0_10", o10, 2'b00);
    apply(5'b00010, "lat");
    check("lat_k1", o11, 2'b00);
    check("lat_k1_10", o10, 2'b11);
    check("lat_k1_01", o01, 2'b11);
    apply(5'b00010, "lat");
    check("lat_k2", o11, 2'b11);

    // Random full-throughput stream with occasional resets.
    for (int i = 0; i < 300; i++) begin
      apply(5'($urandom), "rand");
      if ($urandom_range(0, 19) == 0) mid_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
